seq_shift_unit: RTL and testbench

- Parametrised multi-cycle shift/rotate unit; next generation of the datapath's single-cycle shra path.
- Supports shr, shra, shl, ror and rol on a WIDTH-bit operand, shifting at most STEP bits per cycle.
- Uses a start/done handshake; the datapath control FSM starts an operation and waits for done before its Zlowout step.
- Also reports the last bit shifted out and flags illegal mode codes.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/shift_step.sv | 54 +++++
 rtl/seq_shift_unit.sv | 140 ++++++++++++++
 tb/tb_seq_shift_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shift/rotate datapath: mode codes, FSM states
// and the ALU opcode to shift-mode mapping used by the control FSM.
package alu_pkg;

    localparam logic [2:0] MODE_SHR  = 3'b000;
    localparam logic [2:0] MODE_SHRA = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_BAD  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Codes 101..111 are not defined shift modes.
    function automatic logic mode_is_legal(input logic [2:0] m);
        return (m <= MODE_ROL);
    endfunction

    // Datapath ALUopcode to shift mode; non-shift opcodes map to an illegal code.
    function automatic logic [2:0] opcode_to_mode(input logic [4:0] op);
        logic [2:0] m;
        case (op)
            5'b00111: m = MODE_SHR;
            5'b01000: m = MODE_SHRA;
            5'b01001: m = MODE_SHL;
            5'b01010: m = MODE_ROR;
            5'b01011: m = MODE_ROL;
            default:  m = MODE_BAD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational shift/rotate of a WIDTH-bit word by k bits (k in 1..STEP when
// used), with the last bit moved out reported on cout.
module shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   k,
    output logic [WIDTH-1:0] dout,
    output logic             cout
);

    logic [SHW-1:0] lo_idx;
    logic [SHW-1:0] hi_idx;

    // One step of the selected operation; the carry index wraps modulo WIDTH,
    // so hi_idx is WIDTH-k and a rotate by 0 degenerates to din.
    always_comb begin
        lo_idx = k - SHW'(1);
        hi_idx = SHW'(0) - k;
        dout   = din;
        cout   = 1'b0;
        case (mode)
            MODE_SHR: begin
                dout = din >> k;
                cout = din[lo_idx];
            end
            MODE_SHRA: begin
                dout = $signed(din) >>> k;
                cout = din[lo_idx];
            end
            MODE_SHL: begin
                dout = din << k;
                cout = din[hi_idx];
            end
            MODE_ROR: begin
                dout = (din >> k) | (din << hi_idx);
                cout = din[lo_idx];
            end
            MODE_ROL: begin
                dout = (din << k) | (din >> hi_idx);
                cout = din[hi_idx];
            end
            default: begin
                dout = din;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: moves at most STEP bits per cycle under a
// start/done handshake. The accept edge already performs the first step, so
// done is high in cycle max(1, ceil(amt/STEP)) counted from the accept edge.
module seq_shift_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             illegal
);

    localparam logic [SHW-1:0] STEP_K = SHW'(STEP);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] work_reg, work_next;
    logic [2:0]       mode_reg, mode_next;
    logic [SHW-1:0]   rem_reg, rem_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             carry_reg, carry_next;
    logic             illegal_reg, illegal_next;

    logic             accept;
    logic [WIDTH-1:0] step_in, step_out;
    logic [2:0]       step_mode;
    logic [SHW-1:0]   step_rem, step_k, rem_after;
    logic             step_cout;

    // Step operands come from the ports on an accept, else from the working registers.
    always_comb begin
        accept    = start && (state_reg != ST_SHIFT);
        step_in   = accept ? a    : work_reg;
        step_mode = accept ? mode : mode_reg;
        step_rem  = accept ? amt  : rem_reg;
        step_k    = (step_rem > STEP_K) ? STEP_K : step_rem;
        rem_after = step_rem - step_k;
    end

    shift_step #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_step (
        .mode (step_mode),
        .din  (step_in),
        .k    (step_k),
        .dout (step_out),
        .cout (step_cout)
    );

    // Next-state, working-register and result-load logic.
    always_comb begin
        state_next   = state_reg;
        work_next    = work_reg;
        mode_next    = mode_reg;
        rem_next     = rem_reg;
        result_next  = result_reg;
        carry_next   = carry_reg;
        illegal_next = illegal_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                state_next = ST_IDLE;
                if (start) begin
                    mode_next = mode;
                    if (!mode_is_legal(mode) || (amt == '0)) begin
                        // Nothing to shift: pass the operand straight through.
                        state_next   = ST_DONE;
                        work_next    = a;
                        rem_next     = '0;
                        result_next  = a;
                        carry_next   = 1'b0;
                        illegal_next = !mode_is_legal(mode);
                    end else begin
                        work_next = step_out;
                        rem_next  = rem_after;
                        if (rem_after == '0) begin
                            state_next   = ST_DONE;
                            result_next  = step_out;
                            carry_next   = step_cout;
                            illegal_next = 1'b0;
                        end else begin
                            state_next = ST_SHIFT;
                        end
                    end
                end
            end
            ST_SHIFT: begin
                work_next = step_out;
                rem_next  = rem_after;
                if (rem_after == '0) begin
                    state_next   = ST_DONE;
                    result_next  = step_out;
                    carry_next   = step_cout;
                    illegal_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; clr abandons any operation in flight.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg   <= ST_IDLE;
            work_reg    <= '0;
            mode_reg    <= '0;
            rem_reg     <= '0;
            result_reg  <= '0;
            carry_reg   <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            work_reg    <= work_next;
            mode_reg    <= mode_next;
            rem_reg     <= rem_next;
            result_reg  <= result_next;
            carry_reg   <= carry_next;
            illegal_reg <= illegal_next;
        end
    end

    assign busy      = (state_reg == ST_SHIFT);
    assign done      = (state_reg == ST_DONE);
    assign result    = result_reg;
    assign carry_out = carry_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit (WIDTH=32, STEP=4): directed cases
// followed by random operations checked against an arithmetic reference model.
module tb_seq_shift_unit;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             clr;
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   amt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             illegal;

    int tests  = 0;
    int failed = 0;

    logic [31:0] exp_r;
    logic        exp_c;
    logic        exp_il;

    always #5 clk = ~clk;

    seq_shift_unit #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .mode      (mode),
        .a         (a),
        .amt       (amt),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .illegal   (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: single-cycle semantics of each mode, plus handshake latency.
    function automatic void model(input logic [2:0] m, input logic [31:0] av, input int n,
                                  output logic [31:0] r, output logic c, output logic il,
                                  output int lat);
        il  = (m > 3'd4);
        r   = av;
        c   = 1'b0;
        lat = (il || n == 0) ? 1 : (n + STEP - 1) / STEP;
        if (!il && n != 0) begin
            case (m)
                3'd0: begin r = av >> n; c = av[n-1]; end
                3'd1: begin r = 32'($signed(av) >>> n); c = av[n-1]; end
                3'd2: begin r = av << n; c = av[32-n]; end
                3'd3: begin r = (av >> n) | (av << (32 - n)); c = r[31]; end
                default: begin r = (av << n) | (av >> (32 - n)); c = r[0]; end
            endcase
        end
    endfunction

    // Drive a request for one edge, then scramble the inputs.
    task automatic start_op(input logic [2:0] m, input logic [31:0] av, input logic [4:0] n);
        start = 1'b1;
        mode  = m;
        a     = av;
        amt   = n;
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        amt   = 5'($urandom);
        mode  = 3'($urandom);
    endtask

    // Called in cycle 1 after the accept edge; optionally pokes start while busy.
    task automatic wait_done(input string tag, input logic [2:0] m, input logic [31:0] av,
                             input int n, input int poke);
        int lat;
        int cyc;
        model(m, av, n, exp_r, exp_c, exp_il, lat);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (cyc == poke) begin
                start = 1'b1;
                mode  = 3'b010;
                a     = $urandom;
                amt   = 5'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(lat));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_result"}, result, exp_r);
        chk({tag, "_carry"}, 32'(carry_out), 32'(exp_c));
        chk({tag, "_illegal"}, 32'(illegal), 32'(exp_il));
        $display("[TB] %s mode=%0d a=%h amt=%0d -> result=%h carry=%0b illegal=%0b cycles=%0d",
                 tag, m, av, n, result, carry_out, illegal, cyc);
    endtask

    // One cycle after DONE: back in IDLE with outputs held.
    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_hold_result"}, result, exp_r);
        chk({tag, "_hold_carry"}, 32'(carry_out), 32'(exp_c));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  m;
        logic [31:0] av;
        int          n;
        int          poke;
        logic        b2b;

        clr   = 1'b0;
        start = 1'b0;
        mode  = '0;
        a     = '0;
        amt   = '0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_carry", 32'(carry_out), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        start_op(3'd1, 32'hF2B80000, 5'd2);
        wait_done("shra_2", 3'd1, 32'hF2B80000, 2, 0);
        idle_check("shra_2");

        start_op(3'd0, 32'h80000001, 5'd31);
        wait_done("shr_31", 3'd0, 32'h80000001, 31, 0);
        idle_check("shr_31");

        start_op(3'd3, 32'h00000018, 5'd5);
        wait_done("ror_5", 3'd3, 32'h00000018, 5, 0);
        start_op(3'd4, 32'h80000001, 5'd1);
        wait_done("rol_1_b2b", 3'd4, 32'h80000001, 1, 0);
        idle_check("rol_1_b2b");

        start_op(3'd2, 32'h00000018, 5'd0);
        wait_done("shl_0", 3'd2, 32'h00000018, 0, 0);
        idle_check("shl_0");
        start_op(3'd6, 32'h12345678, 5'd7);
        wait_done("illegal_6", 3'd6, 32'h12345678, 7, 0);
        idle_check("illegal_6");

        start_op(3'd0, 32'hFFFFFFFF, 5'd16);
        wait_done("shr_16_poke", 3'd0, 32'hFFFFFFFF, 16, 2);
        idle_check("shr_16_poke");

        // Asynchronous reset in the middle of a shift.
        start_op(3'd1, 32'h80000000, 5'd20);
        chk("rst_mid_busy1", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("rst_mid_busy2", 32'(busy), 32'd1);
        clr = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_carry", 32'(carry_out), 32'd0);
        chk("rst_mid_illegal", 32'(illegal), 32'd0);
        @(posedge clk); #1;
        clr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("rst_no_done", 32'(done), 32'd0);
        end
        start_op(3'd1, 32'h80000000, 5'd20);
        wait_done("shra_20_after_rst", 3'd1, 32'h80000000, 20, 0);
        idle_check("shra_20_after_rst");

        // Random operations, with occasional back-to-back starts and ignored pokes.
        b2b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) m = 3'($urandom_range(5, 7));
            else                           m = 3'($urandom_range(0, 4));
            av   = $urandom;
            n    = $urandom_range(0, 31);
            poke = $urandom_range(0, 3);
            start_op(m, av, 5'(n));
            wait_done($sformatf("rand%0d", i), m, av, n, poke);
            b2b = ($urandom_range(0, 2) == 0);
            if (!b2b) idle_check($sformatf("rand%0d", i));
        end
        if (b2b) idle_check("rand_last");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
